// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler.
// Slot field layout: {en, bcd[3:0], dp}; slot 0 sits in bits [5:0] of a 48-bit bus.
// Modes are ordered by display priority (RING > MSG > EDIT > TIME).
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_TIME = 2'd0,
    MODE_EDIT = 2'd1,
    MODE_MSG  = 2'd2,
    MODE_RING = 2'd3
  } mode_t;

  typedef logic [5:0] slot_t;

  localparam slot_t SLOT_BLANK = 6'd0;
  localparam int    EN_BIT     = 5;
  localparam int    DP_BIT     = 0;
  localparam int    NUM_SLOTS  = 8;

  // Clear the enable bit of a slot so the driver blanks that digit.
  function automatic slot_t clr_en(slot_t s);
    slot_t r;
    r         = s;
    r[EN_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/disp_scheduler_blink_prescaler.sv
// Blink prescaler: divides clk into blink half-periods and tracks the blink phase.
// Latency: tick is combinational from the count; phase updates on the tick edge.
// No backpressure; i_restart clears the count and forces phase on for the next cycle.
// Ports: i_clk, i_rst_n (async active-low), i_restart -> o_tick, o_phase (1 = on).
module blink_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick,
  output logic o_phase
);

  localparam int CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_term;

  // Tick depends only on state so the scheduler can feed it back into
  // its mode decision (and from there into i_restart) without a loop.
  assign w_term  = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick  = w_term;
  assign o_phase = r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_term) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/disp_scheduler.sv
// Display scheduler: picks RING/MSG/EDIT/TIME content for eight digit slots.
// Latency: one cycle from any input to the registered slot/mode/ack/busy outputs.
// Message handshake: msg_req held until a one-cycle msg_ack; held off while ringing or busy.
// Ports: i_clk, i_rst_n, i_time_dig, i_alarm_dig, i_alarm_edit, i_edit_field, i_ringing,
//        i_msg_req, i_msg_data -> o_msg_ack, o_msg_busy, o_l0..o_l7, o_mode.
// Build option: define DISP_SCHED_BLINK_EN to blank edited/ringing digits on the off phase.
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MSG_HOLD = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [47:0] i_time_dig,
  input  logic [47:0] i_alarm_dig,
  input  logic        i_alarm_edit,
  input  logic [1:0]  i_edit_field,
  input  logic        i_ringing,
  input  logic        i_msg_req,
  input  logic [47:0] i_msg_data,
  output logic        o_msg_ack,
  output logic        o_msg_busy,
  output logic [5:0]  o_l0,
  output logic [5:0]  o_l1,
  output logic [5:0]  o_l2,
  output logic [5:0]  o_l3,
  output logic [5:0]  o_l4,
  output logic [5:0]  o_l5,
  output logic [5:0]  o_l6,
  output logic [5:0]  o_l7,
  output logic [1:0]  o_mode
);

  // A hold of zero ticks would make a message invisible; treat it as one.
  localparam int HOLD   = (MSG_HOLD < 1) ? 1 : MSG_HOLD;
  localparam int HOLD_W = $clog2(HOLD + 1);

  mode_t             r_mode;
  logic              r_busy;
  logic              r_ack;
  logic [47:0]       r_msg;
  logic [HOLD_W-1:0] r_hold_cnt;
  slot_t             r_l [NUM_SLOTS];

  logic              w_tick;
  logic              w_phase;
  logic              w_accept;
  logic              w_hold_done;
  logic              w_busy_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  mode_t             w_mode_nxt;
  logic              w_restart;
  logic              w_phase_nxt;
  logic [47:0]       w_msg_nxt;
  slot_t             w_l_nxt [NUM_SLOTS];

  blink_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick),
    .o_phase   (w_phase)
  );

  // Message handshake and hold timing.
  always_comb begin
    w_accept    = i_msg_req && !r_busy && !i_ringing;
    w_hold_done = r_busy && w_tick && (r_hold_cnt == HOLD_W'(HOLD - 1));
    w_msg_nxt   = w_accept ? i_msg_data : r_msg;

    // Ringing aborts a message outright; the hold count only runs while busy.
    w_busy_nxt = r_busy;
    if (i_ringing) begin
      w_busy_nxt = 1'b0;
    end else if (w_accept) begin
      w_busy_nxt = 1'b1;
    end else if (w_hold_done) begin
      w_busy_nxt = 1'b0;
    end

    w_hold_nxt = r_hold_cnt;
    if (!w_busy_nxt || w_accept) begin
      w_hold_nxt = '0;
    end else if (w_tick) begin
      w_hold_nxt = r_hold_cnt + HOLD_W'(1);
    end
  end

  // Mode priority is evaluated against next-cycle busy so that mode, busy
  // and the displayed message all switch on the same edge.
  always_comb begin
    if (i_ringing) begin
      w_mode_nxt = MODE_RING;
    end else if (w_busy_nxt) begin
      w_mode_nxt = MODE_MSG;
    end else if (i_alarm_edit) begin
      w_mode_nxt = MODE_EDIT;
    end else begin
      w_mode_nxt = MODE_TIME;
    end
  end

  assign w_restart = (w_mode_nxt != r_mode);

  // Slots are registered from the phase the prescaler will hold next cycle,
  // keeping the blanking aligned with the half-period it belongs to.
`ifdef DISP_SCHED_BLINK_EN
  assign w_phase_nxt = w_restart ? 1'b1 : (w_tick ? ~w_phase : w_phase);
`else
  logic w_unused_phase;
  assign w_unused_phase = w_phase;
  assign w_phase_nxt    = 1'b1;
`endif

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_l_nxt[i] = SLOT_BLANK;
      case (w_mode_nxt)
        MODE_TIME: w_l_nxt[i] = i_time_dig[i*6 +: 6];
        MODE_EDIT: begin
          w_l_nxt[i] = i_alarm_dig[i*6 +: 6];
          if (!w_phase_nxt && ((i >> 1) == int'(i_edit_field))) begin
            w_l_nxt[i] = clr_en(w_l_nxt[i]);
          end
        end
        MODE_MSG:  w_l_nxt[i] = w_msg_nxt[i*6 +: 6];
        default: begin
          w_l_nxt[i] = i_time_dig[i*6 +: 6];
          if (!w_phase_nxt) begin
            w_l_nxt[i] = clr_en(w_l_nxt[i]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= MODE_TIME;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_msg      <= '0;
      r_hold_cnt <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_l[i] <= SLOT_BLANK;
      end
    end else begin
      r_mode     <= w_mode_nxt;
      r_busy     <= w_busy_nxt;
      r_ack      <= w_accept;
      r_msg      <= w_msg_nxt;
      r_hold_cnt <= w_hold_nxt;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_l[i] <= w_l_nxt[i];
      end
    end
  end

  assign o_msg_ack  = r_ack;
  assign o_msg_busy = r_busy;
  assign o_mode     = r_mode;
  assign o_l0       = r_l[0];
  assign o_l1       = r_l[1];
  assign o_l2       = r_l[2];
  assign o_l3       = r_l[3];
  assign o_l4       = r_l[4];
  assign o_l5       = r_l[5];
  assign o_l6       = r_l[6];
  assign o_l7       = r_l[7];

endmodule

// File: tb/tb_disp_scheduler.sv
// Self-checking bench for disp_scheduler with TICK_DIV=4, MSG_HOLD=2.
// Reference model tracks mode age in cycles; blink phase and message expiry
// are derived arithmetically from that age.
module tb_disp_scheduler;

  localparam int TICK  = 4;
  localparam int MHOLD = 2;
  localparam int HOLD  = (MHOLD < 1) ? 1 : MHOLD;
`ifdef DISP_SCHED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] time_dig, alarm_dig, msg_data;
  logic        alarm_edit, ringing, msg_req;
  logic [1:0]  edit_field;
  logic        msg_ack, msg_busy;
  logic [5:0]  l0, l1, l2, l3, l4, l5, l6, l7;
  logic [1:0]  mode;
  logic [47:0] l_bus;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_mode;
  int          m_age;
  logic        m_busy;
  logic        m_ack;
  logic [47:0] m_msg;
  logic [47:0] e_l;

  always #5 clk = ~clk;

  assign l_bus = {l7, l6, l5, l4, l3, l2, l1, l0};

  disp_scheduler #(
    .TICK_DIV (TICK),
    .MSG_HOLD (MHOLD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_time_dig   (time_dig),
    .i_alarm_dig  (alarm_dig),
    .i_alarm_edit (alarm_edit),
    .i_edit_field (edit_field),
    .i_ringing    (ringing),
    .i_msg_req    (msg_req),
    .i_msg_data   (msg_data),
    .o_msg_ack    (msg_ack),
    .o_msg_busy   (msg_busy),
    .o_l0         (l0),
    .o_l1         (l1),
    .o_l2         (l2),
    .o_l3         (l3),
    .o_l4         (l4),
    .o_l5         (l5),
    .o_l6         (l6),
    .o_l7         (l7),
    .o_mode       (mode)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_age  = 0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
    m_msg  = '0;
    e_l    = '0;
  endtask

  // One clock of behaviour, from the inputs present at the rising edge.
  task automatic model_step();
    logic accept, busy_n, ph;
    int   mode_n, age_n;
    logic [5:0] s;
    accept = msg_req && !m_busy && !ringing;
    if (ringing)                                   busy_n = 1'b0;
    else if (accept)                               busy_n = 1'b1;
    else if (m_busy && (m_age + 1) >= HOLD * TICK) busy_n = 1'b0;
    else                                           busy_n = m_busy;
    mode_n = ringing ? 3 : (busy_n ? 2 : (alarm_edit ? 1 : 0));
    age_n  = (mode_n == m_mode) ? m_age + 1 : 0;
    ph     = BLINK ? (((age_n / TICK) % 2) == 0) : 1'b1;
    if (accept) m_msg = msg_data;
    for (int i = 0; i < 8; i++) begin
      if (mode_n == 0)      s = time_dig[i*6 +: 6];
      else if (mode_n == 2) s = m_msg[i*6 +: 6];
      else if (mode_n == 1) begin
        s = alarm_dig[i*6 +: 6];
        if (!ph && (i / 2) == int'(edit_field)) s[5] = 1'b0;
      end else begin
        s = time_dig[i*6 +: 6];
        if (!ph) s[5] = 1'b0;
      end
      e_l[i*6 +: 6] = s;
    end
    m_mode = mode_n;
    m_age  = age_n;
    m_busy = busy_n;
    m_ack  = accept;
  endtask

  task automatic check_all();
    chk("mode",  48'(mode),     48'(m_mode));
    chk("ack",   48'(msg_ack),  48'(m_ack));
    chk("busy",  48'(msg_busy), 48'(m_busy));
    chk("slots", l_bus,         e_l);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic logic [47:0] mk_slots(input int base);
    logic [47:0] v;
    for (int i = 0; i < 8; i++) v[i*6 +: 6] = {1'b1, 4'((base + i) % 10), 1'(i & 1)};
    return v;
  endfunction

  initial begin
    int   cnt;
    int   acks;
    logic [7:0] pat;

    // Reset asserted with every input active: outputs blank before any edge.
    rst_n      = 1'b0;
    time_dig   = '1;
    alarm_dig  = '1;
    msg_data   = '1;
    alarm_edit = 1'b1;
    ringing    = 1'b1;
    msg_req    = 1'b1;
    edit_field = 2'd3;
    #2;
    chk("rst_slots", l_bus, 48'd0);
    chk("rst_mode",  48'(mode), 48'd0);
    chk("rst_ack",   48'(msg_ack), 48'd0);
    chk("rst_busy",  48'(msg_busy), 48'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_slots", l_bus, 48'd0);

    // Release with plain time display of slots 1..8.
    alarm_edit = 1'b0;
    ringing    = 1'b0;
    msg_req    = 1'b0;
    edit_field = 2'd0;
    time_dig   = mk_slots(1);
    alarm_dig  = mk_slots(5);
    msg_data   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    chk("time_first", l_bus, mk_slots(1));
    step();

    // Alarm edit: slots 2,3 blink with a full on half-period first.
    alarm_edit = 1'b1;
    edit_field = 2'd1;
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      pat = {pat[6:0], l2[5]};
    end
    chk("edit_en_pattern", 48'(pat), BLINK ? 48'h0F0 >> 4 << 4 : 48'hFF);
    edit_field = 2'd2;
    repeat (6) step();
    alarm_edit = 1'b0;
    step();

    // Message 48'hABC: one ack, busy for HOLD*TICK cycles.
    msg_req  = 1'b1;
    msg_data = 48'hABC;
    step();
    chk("msg_ack_first", 48'(msg_ack), 48'd1);
    chk("msg_slots", l_bus, 48'hABC);
    msg_req = 1'b0;
    cnt = msg_busy ? 1 : 0;
    acks = 0;
    for (int k = 0; k < 30 && msg_busy; k++) begin
      if (k == 3) alarm_edit = 1'b1;
      step();
      if (msg_busy) cnt++;
      if (msg_ack) acks++;
    end
    chk("msg_busy_len", 48'(cnt), 48'(HOLD * TICK));
    chk("msg_extra_ack", 48'(acks), 48'd0);
    step();
    alarm_edit = 1'b0;
    step();

    // Ringing aborts a message and holds off a new request.
    msg_req  = 1'b1;
    msg_data = 48'h1234_5678_9ABC;
    for (int k = 0; k < 10 && !msg_ack; k++) step();
    chk("abort_ack_seen", 48'(msg_ack), 48'd1);
    msg_req = 1'b0;
    repeat (2) step();
    ringing = 1'b1;
    step();
    chk("abort_busy", 48'(msg_busy), 48'd0);
    chk("abort_mode", 48'(mode), 48'd3);
    msg_req  = 1'b1;
    msg_data = 48'hFEDC_BA98_7654;
    acks = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (msg_ack) acks++;
    end
    chk("ring_holdoff", 48'(acks), 48'd0);
    ringing = 1'b0;
    step();
    chk("ring_release_ack", 48'(msg_ack), 48'd1);

    // Request held across completion is re-accepted right after busy clears.
    for (int k = 0; k < 30 && msg_busy; k++) step();
    chk("held_busy_cleared", 48'(msg_busy), 48'd0);
    step();
    chk("held_reack", 48'(msg_ack), 48'd1);
    msg_req = 1'b0;
    for (int k = 0; k < 30 && msg_busy; k++) step();
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if (!msg_req && $urandom_range(0, 7) == 0) begin
        msg_req  = 1'b1;
        msg_data = 48'({$urandom, $urandom});
      end
      if ($urandom_range(0, 39) == 0) ringing    = ~ringing;
      if ($urandom_range(0, 14) == 0) alarm_edit = ~alarm_edit;
      if ($urandom_range(0, 9) == 0)  edit_field = 2'($urandom);
      if ($urandom_range(0, 4) == 0)  time_dig   = 48'({$urandom, $urandom});
      if ($urandom_range(0, 6) == 0)  alarm_dig  = 48'({$urandom, $urandom});
      step();
      if (msg_ack) msg_req = 1'b0;
    end

    // Asynchronous reset mid-run, then normal evaluation on the first edge.
    msg_req  = 1'b1;
    msg_data = 48'h0000_0000_0FFF;
    ringing  = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_slots", l_bus, 48'd0);
    chk("arst_busy",  48'(msg_busy), 48'd0);
    chk("arst_mode",  48'(mode), 48'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ack", 48'(msg_ack), 48'd1);
    msg_req = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
